// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe game-state controller: cursor, board contents, turn alternation
// and win/draw detection, with every output driven straight from a register.
module ttt_board_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        left,
  input  logic        right,
  input  logic        place,
  input  logic        restart,
  output logic [17:0] board,
  output logic [3:0]  cursor,
  output logic        turn,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        illegal
);

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_WIN  = 2'd1,
    ST_DRAW = 2'd2
  } state_t;

  localparam logic [3:0] CURSOR_HOME = 4'd4;
  localparam logic [3:0] CURSOR_MAX  = 4'd8;
  localparam logic [1:0] MARK_EMPTY  = 2'b00;
  localparam logic [1:0] MARK_X      = 2'b01;
  localparam logic [1:0] MARK_O      = 2'b10;
  localparam logic [1:0] WINNER_DRAW = 2'b11;

  state_t      r_state;
  logic [17:0] r_board;
  logic [3:0]  r_cursor;
  logic        r_turn;
  logic        r_game_over;
  logic [1:0]  r_winner;
  logic        r_illegal;

  logic [1:0]  w_mark;
  logic [1:0]  w_cell_cur;
  logic [17:0] w_mark_vec;
  logic [17:0] w_next_board;
  logic [1:0]  w_next_win;
  logic        w_next_full;
  logic [3:0]  w_cursor_next;

  function automatic logic [1:0] f_cell(input logic [17:0] b, input int idx);
    return b[2*idx +: 2];
  endfunction

  // A line wins only when all three cells carry the same non-empty mark.
  function automatic logic [1:0] f_line(input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] c);
    if ((a != MARK_EMPTY) && (a == b) && (b == c)) begin
      return a;
    end else begin
      return MARK_EMPTY;
    end
  endfunction

  // Only the mark just placed can complete a line, so OR-ing the lines is safe.
  function automatic logic [1:0] f_board_winner(input logic [17:0] b);
    logic [1:0] v;
    v = f_line(f_cell(b, 0), f_cell(b, 1), f_cell(b, 2))
      | f_line(f_cell(b, 3), f_cell(b, 4), f_cell(b, 5))
      | f_line(f_cell(b, 6), f_cell(b, 7), f_cell(b, 8))
      | f_line(f_cell(b, 0), f_cell(b, 3), f_cell(b, 6))
      | f_line(f_cell(b, 1), f_cell(b, 4), f_cell(b, 7))
      | f_line(f_cell(b, 2), f_cell(b, 5), f_cell(b, 8))
      | f_line(f_cell(b, 0), f_cell(b, 4), f_cell(b, 8))
      | f_line(f_cell(b, 2), f_cell(b, 4), f_cell(b, 6));
    return v;
  endfunction

  function automatic logic f_board_full(input logic [17:0] b);
    logic full;
    full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      full = full & (f_cell(b, i) != MARK_EMPTY);
    end
    return full;
  endfunction

  // Candidate board with the current player's mark written at the cursor.
  always_comb begin
    w_mark       = r_turn ? MARK_O : MARK_X;
    w_cell_cur   = 2'(r_board >> {r_cursor, 1'b0});
    w_mark_vec   = {16'b0, w_mark} << {r_cursor, 1'b0};
    w_next_board = r_board | w_mark_vec;
    w_next_win   = f_board_winner(w_next_board);
    w_next_full  = f_board_full(w_next_board);
  end

  // Cursor step with wrap-around; opposing pulses cancel.
  always_comb begin
    w_cursor_next = r_cursor;
    if (right && !left) begin
      if (r_cursor >= CURSOR_MAX) begin
        w_cursor_next = 4'd0;
      end else begin
        w_cursor_next = r_cursor + 4'd1;
      end
    end else if (left && !right) begin
      if (r_cursor == 4'd0) begin
        w_cursor_next = CURSOR_MAX;
      end else begin
        w_cursor_next = r_cursor - 4'd1;
      end
    end else begin
      w_cursor_next = r_cursor;
    end
  end

  // Game FSM: clear on reset/restart, otherwise place, move or hold.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_state     <= ST_PLAY;
      r_board     <= 18'd0;
      r_cursor    <= CURSOR_HOME;
      r_turn      <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= 2'b00;
      r_illegal   <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        ST_PLAY: begin
          if (place) begin
            if (w_cell_cur == MARK_EMPTY) begin
              r_board <= w_next_board;
              if (w_next_win != MARK_EMPTY) begin
                r_state     <= ST_WIN;
                r_winner    <= w_next_win;
                r_game_over <= 1'b1;
              end else if (w_next_full) begin
                r_state     <= ST_DRAW;
                r_winner    <= WINNER_DRAW;
                r_game_over <= 1'b1;
              end else begin
                r_turn <= ~r_turn;
              end
            end else begin
              r_illegal <= 1'b1;
            end
          end else begin
            r_cursor <= w_cursor_next;
          end
        end
        ST_WIN, ST_DRAW: begin
          r_state <= r_state;
        end
        default: begin
          r_state     <= ST_PLAY;
          r_board     <= 18'd0;
          r_cursor    <= CURSOR_HOME;
          r_turn      <= 1'b0;
          r_game_over <= 1'b0;
          r_winner    <= 2'b00;
        end
      endcase
    end
  end

  assign board     = r_board;
  assign cursor    = r_cursor;
  assign turn      = r_turn;
  assign game_over = r_game_over;
  assign winner    = r_winner;
  assign illegal   = r_illegal;

endmodule
